// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package mem_arbiter_pkg;

  // Arbiter FSM: idle, or waiting on an outstanding fetch / data access.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY_FETCH = 2'd1,
    BUSY_DATA  = 2'd2
  } ArbStateT;

  // Which requester owns the memory bus in the current cycle.
  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_FETCH = 2'd1,
    GRANT_DATA  = 2'd2
  } GrantT;

  localparam int          MEM_LATENCY_DEFAULT = 2;
  localparam int          BYTE_EN_WIDTH       = 4;
  localparam logic [3:0]  BYTE_EN_ALL         = 4'hF;
  localparam int          CONFLICT_WIDTH      = 16;
  localparam logic [15:0] CONFLICT_MAX        = 16'hFFFF;

  // Fixed priority: data (older instruction) wins, unless the data side has
  // just completed and fetch is waiting, in which case fetch goes first so a
  // completing load/store cannot starve fetch.
  function automatic GrantT pickGrant(input logic fetchReq,
                                      input logic dataReq,
                                      input logic fetchFirst);
    if (fetchFirst && fetchReq) return GRANT_FETCH;
    if (dataReq)                return GRANT_DATA;
    if (fetchReq)               return GRANT_FETCH;
    return GRANT_NONE;
  endfunction

endpackage

// File: rtl/arb_latency_counter.sv
// Memory latency down-counter: loaded with LATENCY-1 on issue, counts to zero.
// Latency: oZero is combinational from the count register; load takes effect next cycle.
// Backpressure: none; the counter always accepts a load.
//
// Ports:
//   iClk, iRst : clock, synchronous active-high reset (count -> 0)
//   iLoad      : restart the count at LATENCY-1
//   oZero      : count has reached zero (response due this cycle when busy)
module arb_latency_counter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iLoad,
  output logic oZero
);

  localparam int             CW       = $clog2(LATENCY + 1);
  localparam logic [CW-1:0]  LOAD_VAL = CW'(LATENCY - 1);
  localparam logic [CW-1:0]  ONE      = CW'(1);

  logic [CW-1:0] count;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      count <= '0;
    end else if (iLoad) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign oZero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-ported memory.
// Latency: issue is combinational in the request cycle; response valid LATENCY cycles later.
// Backpressure: requesters hold their request and are stalled (oStall*) until their valid pulse.
//
// Ports:
//   iClk, iRst                       : clock, synchronous active-high reset
//   iFetchReq/iFetchAddr             : fetch request; oFetchData/oFetchValid response
//   iDataReq/We/Addr/WData/ByteEn    : load/store request; oDataRData/oDataValid response
//   oStallFetch, oStallData          : stall requests to the hazard unit
//   oMem*, iMemRData                 : memory issue bus and read data
//   oConflictCount                   : saturating count of cycles fetch lost to data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY    = MEM_LATENCY_DEFAULT,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iFetchReq,
  input  logic [ADDR_WIDTH-1:0]     iFetchAddr,
  output logic [DATA_WIDTH-1:0]     oFetchData,
  output logic                      oFetchValid,
  input  logic                      iDataReq,
  input  logic                      iDataWe,
  input  logic [ADDR_WIDTH-1:0]     iDataAddr,
  input  logic [DATA_WIDTH-1:0]     iDataWData,
  input  logic [BYTE_EN_WIDTH-1:0]  iDataByteEn,
  output logic [DATA_WIDTH-1:0]     oDataRData,
  output logic                      oDataValid,
  output logic                      oStallFetch,
  output logic                      oStallData,
  output logic                      oMemReq,
  output logic                      oMemWe,
  output logic [ADDR_WIDTH-1:0]     oMemAddr,
  output logic [DATA_WIDTH-1:0]     oMemWData,
  output logic [BYTE_EN_WIDTH-1:0]  oMemByteEn,
  input  logic [DATA_WIDTH-1:0]     iMemRData,
  output logic [CONFLICT_WIDTH-1:0] oConflictCount
);

  ArbStateT state;
  ArbStateT stateNext;
  GrantT    grant;
  logic     cntLoad;
  logic     cntZero;

  arb_latency_counter #(
    .LATENCY (LATENCY)
  ) uLatCnt (
    .iClk  (iClk),
    .iRst  (iRst),
    .iLoad (cntLoad),
    .oZero (cntZero)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // The memory captures the issue bus on the issue cycle itself, so the
  // transaction is fixed at that point; afterwards the bus is forced to zero
  // and requester changes cannot reach the memory.
  always_comb begin
    stateNext   = state;
    grant       = GRANT_NONE;
    cntLoad     = 1'b0;
    oFetchValid = 1'b0;
    oFetchData  = '0;
    oDataValid  = 1'b0;
    oDataRData  = '0;
    oMemReq     = 1'b0;
    oMemWe      = 1'b0;
    oMemAddr    = '0;
    oMemWData   = '0;
    oMemByteEn  = '0;

    // Reset discards any in-flight access: no completion and no new issue.
    if (!iRst) begin
      unique case (state)
        IDLE: begin
          grant = pickGrant(iFetchReq, iDataReq, 1'b0);
        end
        BUSY_FETCH: begin
          if (cntZero) begin
            oFetchValid = 1'b1;
            oFetchData  = iMemRData;
            stateNext   = IDLE;
            grant       = pickGrant(iFetchReq, iDataReq, 1'b0);
          end
        end
        BUSY_DATA: begin
          if (cntZero) begin
            oDataValid = 1'b1;
            oDataRData = iMemRData;
            stateNext  = IDLE;
            grant      = pickGrant(iFetchReq, iDataReq, 1'b1);
          end
        end
        default: begin
          stateNext = IDLE;
        end
      endcase

      unique case (grant)
        GRANT_DATA: begin
          stateNext  = BUSY_DATA;
          cntLoad    = 1'b1;
          oMemReq    = 1'b1;
          oMemWe     = iDataWe;
          oMemAddr   = iDataAddr;
          oMemWData  = iDataWe ? iDataWData : '0;
          oMemByteEn = iDataByteEn;
        end
        GRANT_FETCH: begin
          stateNext  = BUSY_FETCH;
          cntLoad    = 1'b1;
          oMemReq    = 1'b1;
          oMemAddr   = iFetchAddr;
          oMemByteEn = BYTE_EN_ALL;
        end
        default: begin
        end
      endcase
    end
  end

  assign oStallFetch = iFetchReq & ~oFetchValid;
  assign oStallData  = iDataReq & ~oDataValid;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oConflictCount <= '0;
    end else if (iFetchReq && iDataReq && !oFetchValid &&
                 (oConflictCount != CONFLICT_MAX)) begin
      oConflictCount <= oConflictCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  typedef struct {
    int          cyc;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } IssueT;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        chk;
  } RespT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- instance 1: LATENCY=2 -----------------
  logic        rst1 = 1'b1, fetchReq1 = 1'b0, dataReq1 = 1'b0, dataWe1 = 1'b0;
  logic [31:0] fetchAddr1 = '0, dataAddr1 = '0, dataWData1 = '0, memRData1 = '0;
  logic [3:0]  dataBe1 = '0;
  logic [31:0] fetchData1, dataRData1, memAddr1, memWData1;
  logic        fetchValid1, dataValid1, stallFetch1, stallData1, memReq1, memWe1;
  logic [3:0]  memByteEn1;
  logic [15:0] conflictCount1;

  mem_arbiter #(.LATENCY(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut1 (
    .iClk(clk), .iRst(rst1),
    .iFetchReq(fetchReq1), .iFetchAddr(fetchAddr1),
    .oFetchData(fetchData1), .oFetchValid(fetchValid1),
    .iDataReq(dataReq1), .iDataWe(dataWe1), .iDataAddr(dataAddr1),
    .iDataWData(dataWData1), .iDataByteEn(dataBe1),
    .oDataRData(dataRData1), .oDataValid(dataValid1),
    .oStallFetch(stallFetch1), .oStallData(stallData1),
    .oMemReq(memReq1), .oMemWe(memWe1), .oMemAddr(memAddr1),
    .oMemWData(memWData1), .oMemByteEn(memByteEn1),
    .iMemRData(memRData1), .oConflictCount(conflictCount1)
  );

  // ---------------- instance 2: LATENCY=1 streaming -----------------
  logic        rst2 = 1'b1, fetchReq2 = 1'b0;
  logic [31:0] fetchAddr2 = '0, memRData2 = '0;
  logic [31:0] fetchData2, dataRData2, memAddr2, memWData2;
  logic        fetchValid2, dataValid2, stallFetch2, stallData2, memReq2, memWe2;
  logic [3:0]  memByteEn2;
  logic [15:0] conflictCount2;

  mem_arbiter #(.LATENCY(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut2 (
    .iClk(clk), .iRst(rst2),
    .iFetchReq(fetchReq2), .iFetchAddr(fetchAddr2),
    .oFetchData(fetchData2), .oFetchValid(fetchValid2),
    .iDataReq(1'b0), .iDataWe(1'b0), .iDataAddr(32'h0),
    .iDataWData(32'h0), .iDataByteEn(4'h0),
    .oDataRData(dataRData2), .oDataValid(dataValid2),
    .oStallFetch(stallFetch2), .oStallData(stallData2),
    .oMemReq(memReq2), .oMemWe(memWe2), .oMemAddr(memAddr2),
    .oMemWData(memWData2), .oMemByteEn(memByteEn2),
    .iMemRData(memRData2), .oConflictCount(conflictCount2)
  );

  // ---------------- instance 3: LATENCY=15 saturation -----------------
  logic        rst3 = 1'b1, req3 = 1'b0;
  logic [31:0] fetchData3, dataRData3, memAddr3, memWData3;
  logic        fetchValid3, dataValid3, stallFetch3, stallData3, memReq3, memWe3;
  logic [3:0]  memByteEn3;
  logic [15:0] conflictCount3;

  mem_arbiter #(.LATENCY(15), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut3 (
    .iClk(clk), .iRst(rst3),
    .iFetchReq(req3), .iFetchAddr(32'h0),
    .oFetchData(fetchData3), .oFetchValid(fetchValid3),
    .iDataReq(req3), .iDataWe(1'b0), .iDataAddr(32'h0),
    .iDataWData(32'h0), .iDataByteEn(4'hF),
    .oDataRData(dataRData3), .oDataValid(dataValid3),
    .oStallFetch(stallFetch3), .oStallData(stallData3),
    .oMemReq(memReq3), .oMemWe(memWe3), .oMemAddr(memAddr3),
    .oMemWData(memWData3), .oMemByteEn(memByteEn3),
    .iMemRData(32'h0), .oConflictCount(conflictCount3)
  );

  // ---------------- helpers -----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic flagUnexpected(input string name, input logic [127:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event 0x%0h, expected no event at cycle %0d", name, act, cyc);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] memVal(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // ---------------- memory models -----------------
  logic        hReq1 [16];
  logic [31:0] hAddr1 [16];
  logic        hReq2 [16];
  logic [31:0] hAddr2 [16];

  always @(negedge clk) begin
    hReq1[cyc % 16]  = memReq1;
    hAddr1[cyc % 16] = memAddr1;
    hReq2[cyc % 16]  = memReq2;
    hAddr2[cyc % 16] = memAddr2;
  end

  always @(posedge clk) begin
    #1;
    if (cyc >= 2 && hReq1[(cyc - 2) % 16] === 1'b1) memRData1 = memVal(hAddr1[(cyc - 2) % 16]);
    else                                             memRData1 = 32'hBAD0_BAD0;
    if (cyc >= 1 && hReq2[(cyc - 1) % 16] === 1'b1) memRData2 = memVal(hAddr2[(cyc - 1) % 16]);
    else                                             memRData2 = 32'hBAD0_BAD0;
  end

  // ---------------- scoreboards -----------------
  IssueT expIss1[$], expIss2[$];
  RespT  expF1[$], expD1[$], expF2[$];
  IssueT mi1, mi2;
  RespT  mr1, mr2;

  always @(negedge clk) begin
    if (memReq1) begin
      if (expIss1.size() == 0) flagUnexpected("issue1_unexpected", memAddr1);
      else begin
        mi1 = expIss1.pop_front();
        check("issue1_cycle", cyc, mi1.cyc);
        check("issue1_bus", {memWe1, memByteEn1, memAddr1, memWData1},
              {mi1.we, mi1.be, mi1.addr, mi1.wdata});
      end
    end else if (!rst1) begin
      check("idle1_bus_zero", {memWe1, memByteEn1, memAddr1, memWData1}, 0);
    end
    if (fetchValid1) begin
      if (expF1.size() == 0) flagUnexpected("fetch1_unexpected", fetchData1);
      else begin
        mr1 = expF1.pop_front();
        check("fetch1_cycle", cyc, mr1.cyc);
        check("fetch1_data", fetchData1, mr1.data);
      end
    end
    if (dataValid1) begin
      if (expD1.size() == 0) flagUnexpected("data1_unexpected", dataRData1);
      else begin
        mr1 = expD1.pop_front();
        check("data1_cycle", cyc, mr1.cyc);
        if (mr1.chk) check("data1_rdata", dataRData1, mr1.data);
      end
    end
  end

  always @(negedge clk) begin
    if (memReq2) begin
      if (expIss2.size() == 0) flagUnexpected("issue2_unexpected", memAddr2);
      else begin
        mi2 = expIss2.pop_front();
        check("issue2_cycle", cyc, mi2.cyc);
        check("issue2_bus", {memWe2, memByteEn2, memAddr2, memWData2},
              {mi2.we, mi2.be, mi2.addr, mi2.wdata});
      end
    end
    if (fetchValid2) begin
      if (expF2.size() == 0) flagUnexpected("fetch2_unexpected", fetchData2);
      else begin
        mr2 = expF2.pop_front();
        check("fetch2_cycle", cyc, mr2.cyc);
        check("fetch2_data", fetchData2, mr2.data);
      end
    end
    if (dataValid2) flagUnexpected("data2_unexpected", dataRData2);
  end

  // ---------------- stimulus -----------------
  initial begin
    fork
      begin : mainSeq
        int t;
        repeat (3) nextCycle();
        @(negedge clk);
        check("rst_outputs", {memReq1, fetchValid1, dataValid1, memWe1, memAddr1}, 0);
        check("rst_conflict", conflictCount1, 0);
        nextCycle();
        rst1 = 1'b0;
        @(negedge clk);
        check("idle_stalls", {stallFetch1, stallData1}, 0);

        // Fetch only, then back-to-back re-fetch on the completion cycle.
        nextCycle();
        t = cyc;
        fetchReq1 = 1'b1; fetchAddr1 = 32'h100;
        expIss1.push_back('{t, 1'b0, 4'hF, 32'h100, 32'h0});
        expF1.push_back('{t + 2, 32'h0050_0093, 1'b1});
        @(negedge clk); check("A_stallF_T", stallFetch1, 1);
        nextCycle();
        @(negedge clk); check("A_stallF_T1", stallFetch1, 1);
        nextCycle();
        fetchAddr1 = 32'h104;
        expIss1.push_back('{t + 2, 1'b0, 4'hF, 32'h104, 32'h0});
        expF1.push_back('{t + 4, memVal(32'h104), 1'b1});
        @(negedge clk); check("A_stallF_T2", stallFetch1, 0);
        nextCycle();
        fetchReq1 = 1'b0;
        repeat (2) nextCycle();

        // Store, with requester changing and dropping mid-flight.
        nextCycle();
        t = cyc;
        dataReq1 = 1'b1; dataWe1 = 1'b1; dataAddr1 = 32'h40;
        dataWData1 = 32'hDEAD_BEEF; dataBe1 = 4'b0011;
        expIss1.push_back('{t, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF});
        expD1.push_back('{t + 2, 32'h0, 1'b0});
        @(negedge clk); check("B_stallD_T", stallData1, 1);
        nextCycle();
        dataReq1 = 1'b0; dataWe1 = 1'b0; dataAddr1 = 32'hFFC;
        dataWData1 = 32'h1234_5678; dataBe1 = 4'hF;
        repeat (2) nextCycle();

        // Fetch and load together: data first, fetch on data completion.
        nextCycle();
        t = cyc;
        fetchReq1 = 1'b1; fetchAddr1 = 32'h200;
        dataReq1 = 1'b1; dataAddr1 = 32'h2000;
        expIss1.push_back('{t, 1'b0, 4'hF, 32'h2000, 32'h0});
        expD1.push_back('{t + 2, memVal(32'h2000), 1'b1});
        expIss1.push_back('{t + 2, 1'b0, 4'hF, 32'h200, 32'h0});
        expF1.push_back('{t + 4, memVal(32'h200), 1'b1});
        @(negedge clk); check("C_conflict_T", conflictCount1, 0);
        nextCycle();
        @(negedge clk); check("C_stalls_T1", {stallFetch1, stallData1}, 2'b11);
        nextCycle();
        @(negedge clk); check("C_stalls_T2", {stallFetch1, stallData1}, 2'b10);
        nextCycle();
        dataAddr1 = 32'h3000;
        expIss1.push_back('{t + 4, 1'b0, 4'hF, 32'h3000, 32'h0});
        expD1.push_back('{t + 6, memVal(32'h3000), 1'b1});
        nextCycle();
        @(negedge clk); check("C_stallF_T4", stallFetch1, 0);
        nextCycle();
        fetchReq1 = 1'b0; dataReq1 = 1'b0;
        @(negedge clk); check("C_conflict", conflictCount1, 4);
        repeat (2) nextCycle();

        // Reset during an in-flight fetch discards it.
        nextCycle();
        t = cyc;
        fetchReq1 = 1'b1; fetchAddr1 = 32'h500;
        expIss1.push_back('{t, 1'b0, 4'hF, 32'h500, 32'h0});
        nextCycle();
        rst1 = 1'b1;
        @(negedge clk); check("D_rst_quiet", {memReq1, fetchValid1, dataValid1}, 0);
        nextCycle();
        rst1 = 1'b0;
        expIss1.push_back('{t + 2, 1'b0, 4'hF, 32'h500, 32'h0});
        expF1.push_back('{t + 4, memVal(32'h500), 1'b1});
        @(negedge clk);
        check("D_no_valid", fetchValid1, 0);
        check("D_conflict_cleared", conflictCount1, 0);
        nextCycle();
        fetchReq1 = 1'b0;
        repeat (4) nextCycle();
        check("main_drained", expIss1.size() + expF1.size() + expD1.size(), 0);
      end

      begin : streamSeq
        int t;
        repeat (3) nextCycle();
        rst2 = 1'b0;
        nextCycle();
        t = cyc;
        for (int k = 0; k < 8; k++) begin
          fetchReq2  = 1'b1;
          fetchAddr2 = 32'h1000 + 32'(4 * k);
          expIss2.push_back('{t + k, 1'b0, 4'hF, fetchAddr2, 32'h0});
          expF2.push_back('{t + k + 1, memVal(fetchAddr2), 1'b1});
          @(negedge clk);
          check("S_memReq", memReq2, 1);
          if (k > 0) check("S_fetchValid", fetchValid2, 1);
          nextCycle();
        end
        fetchReq2 = 1'b0;
        repeat (3) nextCycle();
        check("stream_drained", expIss2.size() + expF2.size(), 0);
      end

      begin : satSeq
        repeat (2) nextCycle();
        rst3 = 1'b0;
        req3 = 1'b1;
        repeat (100) nextCycle();
        @(negedge clk); check("SAT_early_exact", conflictCount3, 97);
        repeat (69000) nextCycle();
        @(negedge clk); check("SAT_full", conflictCount3, 16'hFFFF);
        repeat (500) nextCycle();
        @(negedge clk); check("SAT_hold", conflictCount3, 16'hFFFF);
        req3 = 1'b0;
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
